pte_mem_responder: RTL and testbench

Memory-side responder for page-table-walk traffic. Accepts single-word PTE read and writeback requests from the MMU page walker, checks each against the DRAM window, and issues the access to the DRAM controller over a req/ack/rvalid handshake. Returns read data with a done/fault indication. Sits between the MMU's PTE port and the DRAM arbiter.

---
 rtl/pte_mem_responder.sv | 144 ++++++++++++++
 tb/tb_pte_mem_responder.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pte_mem_responder.sv
// PTE memory responder: range-checks single-word PTE reads/writebacks from the
// page walker and issues them to DRAM over a req/ack/rvalid handshake.
module pte_mem_responder #(
    parameter logic [31:0] MEM_BASE = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE = 32'h0800_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fault,
    output logic [31:0] o_rdata,
    output logic        o_dram_req,
    output logic        o_dram_we,
    output logic [31:0] o_dram_addr,
    output logic [31:0] o_dram_wdata,
    input  logic        i_dram_ack,
    input  logic        i_dram_rvalid,
    input  logic [31:0] i_dram_rdata,
    output logic [1:0]  o_dbg_state
);

    // Handshake: o_dram_req is held with stable we/addr/wdata until the cycle
    // i_dram_ack is high; read data is taken on i_dram_rvalid in that same
    // cycle or any later WAIT cycle, never after the transaction has ended.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_fault;
    logic [31:0] r_rdata;
    logic [15:0] r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    state_t      w_next;
    logic        w_fault_nxt;
    logic [31:0] w_rdata_nxt;
    logic [15:0] w_cnt_nxt;
    logic        w_accept;
    logic        w_legal;
    logic        w_last;

    assign w_accept = i_req && ((r_state == S_IDLE) || (r_state == S_RESP));
    // 33-bit compare so a window ending exactly at 2^32 does not wrap to zero
    assign w_legal  = (i_addr[1:0] == 2'b00)
                   && ({1'b0, i_addr} >= {1'b0, MEM_BASE})
                   && ({1'b0, i_addr} <  ({1'b0, MEM_BASE} + {1'b0, MEM_SIZE}));
    assign w_last   = (r_cnt == LP_LAST);

    always_comb begin
        w_next      = r_state;
        w_fault_nxt = 1'b0;
        w_rdata_nxt = r_rdata;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_RESP: begin
                w_next = S_IDLE;
                if (w_accept) begin
                    w_cnt_nxt = 16'd0;
                    if (w_legal) begin
                        w_next = S_REQ;
                    end else begin
                        w_next      = S_RESP;
                        w_fault_nxt = 1'b1;
                        if (!i_we) w_rdata_nxt = 32'd0;
                    end
                end
            end
            S_REQ: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (i_dram_ack && r_we) begin
                    w_next = S_RESP;
                end else if (i_dram_ack && i_dram_rvalid) begin
                    w_next      = S_RESP;
                    w_rdata_nxt = i_dram_rdata;
                end else if (w_last) begin
                    w_next      = S_RESP;
                    w_fault_nxt = 1'b1;
                    if (!r_we) w_rdata_nxt = 32'd0;
                end else if (i_dram_ack) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (i_dram_rvalid) begin
                    w_next      = S_RESP;
                    w_rdata_nxt = i_dram_rdata;
                end else if (w_last) begin
                    w_next      = S_RESP;
                    w_fault_nxt = 1'b1;
                    w_rdata_nxt = 32'd0;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            r_state <= S_IDLE;
            r_fault <= 1'b0;
            r_rdata <= 32'd0;
            r_cnt   <= 16'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_fault <= w_fault_nxt;
            r_rdata <= w_rdata_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= i_we;
                r_addr  <= {i_addr[31:2], 2'b00};
                r_wdata <= i_wdata;
            end
        end
    end

    assign o_busy       = (r_state == S_REQ) || (r_state == S_WAIT);
    assign o_done       = (r_state == S_RESP);
    assign o_fault      = r_fault;
    assign o_rdata      = r_rdata;
    assign o_dram_req   = (r_state == S_REQ);
    assign o_dram_we    = r_we;
    assign o_dram_addr  = r_addr;
    assign o_dram_wdata = r_wdata;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pte_mem_responder.sv
// Self-checking bench for pte_mem_responder: cycle-accurate scenario tasks plus
// a scoreboard that pairs every o_done pulse with the expected fault/rdata.
module tb_pte_mem_responder;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic        CLK = 1'b0;
    logic        RST_X;
    logic        i_req, i_we;
    logic [31:0] i_addr, i_wdata;
    logic        o_busy, o_done, o_fault;
    logic [31:0] o_rdata;
    logic        o_dram_req, o_dram_we;
    logic [31:0] o_dram_addr, o_dram_wdata;
    logic        i_dram_ack, i_dram_rvalid;
    logic [31:0] i_dram_rdata;
    logic [1:0]  o_dbg_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          dram_req_cycles = 0;
    logic [32:0] exp_q[$];
    logic [31:0] model_rdata = 32'd0;

    pte_mem_responder #(
        .MEM_BASE(32'h0000_0000),
        .MEM_SIZE(32'h0800_0000),
        .TIMEOUT (4)
    ) dut (
        .CLK          (CLK),
        .RST_X        (RST_X),
        .i_req        (i_req),
        .i_we         (i_we),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_fault      (o_fault),
        .o_rdata      (o_rdata),
        .o_dram_req   (o_dram_req),
        .o_dram_we    (o_dram_we),
        .o_dram_addr  (o_dram_addr),
        .o_dram_wdata (o_dram_wdata),
        .i_dram_ack   (i_dram_ack),
        .i_dram_rvalid(i_dram_rvalid),
        .i_dram_rdata (i_dram_rdata),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge CLK) begin
        if (o_dram_req) dram_req_cycles++;
        if (RST_X && o_done) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: fault=%0b rdata=%h, expected no completion", o_fault, o_rdata);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({o_fault, o_rdata} !== e) begin
                    n_fail++;
                    $display("FAIL sb_result: got fault=%0b rdata=%h, expected fault=%0b rdata=%h",
                             o_fault, o_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        i_req = 1'b0; i_we = 1'b0; i_addr = 32'd0; i_wdata = 32'd0;
        i_dram_ack = 1'b0; i_dram_rvalid = 1'b0; i_dram_rdata = 32'd0;
    endtask

    function automatic logic bench_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a <= 32'h07FF_FFFC);
    endfunction

    // Presents a request for one cycle and records the expected completion.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd);
        i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata;
        if (!bench_legal(addr)) begin
            if (!we) model_rdata = 32'd0;
            exp_q.push_back({1'b1, model_rdata});
        end else begin
            if (!we) model_rdata = rd;
            exp_q.push_back({1'b0, model_rdata});
        end
    endtask

    // Full transaction from IDLE; ends one cycle after the RESP cycle.
    task automatic drive_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rd, input int ack_d, input int rv_d);
        issue(we, addr, wdata, rd);
        tick();
        i_req = 1'b0;
        if (bench_legal(addr)) begin
            for (int k = 0; k < ack_d; k++) tick();
            i_dram_ack = 1'b1;
            if (!we && rv_d == 0) begin
                i_dram_rvalid = 1'b1; i_dram_rdata = rd;
            end
            tick();
            i_dram_ack = 1'b0; i_dram_rvalid = 1'b0;
            if (!we && rv_d > 0) begin
                for (int k = 0; k < rv_d - 1; k++) tick();
                i_dram_rvalid = 1'b1; i_dram_rdata = rd;
                tick();
                i_dram_rvalid = 1'b0;
            end
        end
        n_tests++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL txn_done_timing addr=%h: done=%0b busy=%0b, expected done=1 busy=0", addr, o_done, o_busy);
        end
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST_X = 1'b0;
        idle_inputs();
        tick(); tick();
        n_tests++;
        if ({o_busy, o_done, o_fault, o_rdata, o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata, o_dbg_state}
            !== {3'b000, 32'd0, 2'b00, 32'd0, 32'd0, ST_IDLE}) begin
            n_fail++;
            $display("FAIL reset_values: busy=%0b done=%0b fault=%0b rdata=%h req=%0b we=%0b addr=%h wdata=%h st=%0d, expected all 0",
                     o_busy, o_done, o_fault, o_rdata, o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata, o_dbg_state);
        end
        RST_X = 1'b1;
        tick();
    endtask

    task automatic test_read_wait();
        issue(1'b0, 32'h0000_1000, 32'd0, 32'h2000_00CF);
        tick();
        i_req = 1'b0;
        n_tests++;
        if ({o_busy, o_dram_req, o_dram_we, o_dram_addr} !== {3'b110, 32'h0000_1000}) begin
            n_fail++;
            $display("FAIL read_req_c1: busy=%0b req=%0b we=%0b addr=%h, expected 1 1 0 00001000",
                     o_busy, o_dram_req, o_dram_we, o_dram_addr);
        end
        i_dram_ack = 1'b1;
        tick();
        i_dram_ack = 1'b0;
        n_tests++;
        if ({o_busy, o_dram_req, o_dbg_state} !== {2'b10, ST_WAIT}) begin
            n_fail++;
            $display("FAIL read_wait_c2: busy=%0b req=%0b st=%0d, expected busy=1 req=0 WAIT", o_busy, o_dram_req, o_dbg_state);
        end
        tick();
        n_tests++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL read_wait_c3: busy=%0b, expected 1", o_busy);
        end
        i_dram_rvalid = 1'b1; i_dram_rdata = 32'h2000_00CF;
        tick();
        i_dram_rvalid = 1'b0;
        n_tests++;
        if ({o_done, o_fault, o_busy, o_rdata} !== {3'b100, 32'h2000_00CF}) begin
            n_fail++;
            $display("FAIL read_resp_c4: done=%0b fault=%0b busy=%0b rdata=%h, expected 1 0 0 200000cf",
                     o_done, o_fault, o_busy, o_rdata);
        end
        tick();
        n_tests++;
        if (o_done !== 1'b0 || o_dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL read_idle_c5: done=%0b st=%0d, expected done=0 IDLE", o_done, o_dbg_state);
        end
    endtask

    task automatic test_write_ack_delay();
        issue(1'b1, 32'h0000_1004, 32'h2000_00CF, 32'd0);
        tick();
        i_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            n_tests++;
            if ({o_busy, o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata} !== {3'b111, 32'h0000_1004, 32'h2000_00CF}) begin
                n_fail++;
                $display("FAIL write_req_stable c%0d: busy=%0b req=%0b we=%0b addr=%h wdata=%h", k,
                         o_busy, o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata);
            end
            if (k == 3) i_dram_ack = 1'b1;
            tick();
        end
        i_dram_ack = 1'b0;
        n_tests++;
        if ({o_done, o_fault, o_dram_req, o_rdata} !== {3'b100, 32'h2000_00CF}) begin
            n_fail++;
            $display("FAIL write_done: done=%0b fault=%0b req=%0b rdata=%h, expected 1 0 0 200000cf",
                     o_done, o_fault, o_dram_req, o_rdata);
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3];
        logic [31:0] wd;
        int          req_before;
        bad[0] = 32'h0800_0000; bad[1] = 32'h0000_1002; bad[2] = 32'hFFFF_FFFC;
        req_before = dram_req_cycles;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, bad[i], 32'd0, 32'd0);
            tick();
            i_req = 1'b0;
            n_tests++;
            if ({o_done, o_fault, o_busy, o_dram_req, o_rdata} !== {4'b1100, 32'd0}) begin
                n_fail++;
                $display("FAIL illegal_read %h: done=%0b fault=%0b busy=%0b req=%0b rdata=%h, expected 1 1 0 0 0",
                         bad[i], o_done, o_fault, o_busy, o_dram_req, o_rdata);
            end
            tick();
        end
        n_tests++;
        if (dram_req_cycles != req_before) begin
            n_fail++;
            $display("FAIL illegal_no_dram_req: %0d req cycles seen, expected 0", dram_req_cycles - req_before);
        end
        // top word of the window is legal
        drive_txn(1'b0, 32'h07FF_FFFC, 32'd0, 32'h0BAD_F00D, 0, 0);
        // illegal writeback faults but keeps the last read data
        wd = 32'h1234_5678;
        drive_txn(1'b1, 32'h0800_0000, wd, 32'd0, 0, 0);
    endtask

    task automatic test_timeout();
        issue(1'b0, 32'h0000_2000, 32'd0, 32'd0);
        exp_q.pop_back();
        model_rdata = 32'd0;
        exp_q.push_back({1'b1, 32'd0});
        tick();
        i_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_tests++;
            if (o_busy !== 1'b1 || o_done !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_busy c%0d: busy=%0b done=%0b, expected 1 0", k, o_busy, o_done);
            end
            tick();
        end
        n_tests++;
        if ({o_done, o_fault, o_dram_req, o_rdata} !== {3'b110, 32'd0}) begin
            n_fail++;
            $display("FAIL timeout_fault c5: done=%0b fault=%0b req=%0b rdata=%h, expected 1 1 0 0",
                     o_done, o_fault, o_dram_req, o_rdata);
        end
        i_dram_rvalid = 1'b1; i_dram_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        i_dram_rvalid = 1'b0;
        n_tests++;
        if (o_rdata !== 32'd0 || o_dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL timeout_late_rvalid: rdata=%h st=%0d, expected 0 IDLE", o_rdata, o_dbg_state);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 32'h0000_3000, 32'd0, 32'h1111_1111);
        tick();
        i_req = 1'b0;
        i_dram_ack = 1'b1; i_dram_rvalid = 1'b1; i_dram_rdata = 32'h1111_1111;
        tick();
        i_dram_ack = 1'b0; i_dram_rvalid = 1'b0;
        n_tests++;
        if (o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_done: done=%0b, expected 1", o_done);
        end
        issue(1'b0, 32'h0000_3008, 32'd0, 32'h2222_2222);
        tick();
        i_req = 1'b0;
        n_tests++;
        if ({o_busy, o_dram_req, o_dbg_state, o_dram_addr} !== {2'b11, ST_REQ, 32'h0000_3008}) begin
            n_fail++;
            $display("FAIL b2b_no_gap: busy=%0b req=%0b st=%0d addr=%h, expected 1 1 REQ 00003008",
                     o_busy, o_dram_req, o_dbg_state, o_dram_addr);
        end
        i_dram_ack = 1'b1;
        tick();
        i_dram_ack = 1'b0;
        i_dram_rvalid = 1'b1; i_dram_rdata = 32'h2222_2222;
        tick();
        i_dram_rvalid = 1'b0;
        n_tests++;
        if (o_done !== 1'b1 || o_rdata !== 32'h2222_2222) begin
            n_fail++;
            $display("FAIL b2b_second: done=%0b rdata=%h, expected 1 22222222", o_done, o_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_4000;
        tick();
        i_req = 1'b0;
        i_dram_ack = 1'b1;
        tick();
        i_dram_ack = 1'b0;
        RST_X = 1'b0;
        tick();
        RST_X = 1'b1;
        model_rdata = 32'd0;
        n_tests++;
        if ({o_busy, o_done, o_fault, o_rdata, o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata, o_dbg_state}
            !== {3'b000, 32'd0, 2'b00, 32'd0, 32'd0, ST_IDLE}) begin
            n_fail++;
            $display("FAIL reset_mid_values: busy=%0b done=%0b fault=%0b rdata=%h req=%0b st=%0d, expected all 0",
                     o_busy, o_done, o_fault, o_rdata, o_dram_req, o_dbg_state);
        end
        i_dram_rvalid = 1'b1; i_dram_rdata = 32'hCAFE_F00D;
        tick(); tick();
        i_dram_rvalid = 1'b0;
        n_tests++;
        if (o_done !== 1'b0 || o_rdata !== 32'd0 || o_dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_late_rvalid: done=%0b rdata=%h st=%0d, expected 0 0 IDLE", o_done, o_rdata, o_dbg_state);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic        we;
            logic [31:0] addr;
            we   = 1'($urandom_range(0, 1));
            addr = $urandom_range(0, 32'h07FF_FFFF) & 32'hFFFF_FFFC;
            case ($urandom_range(0, 5))
                0: addr = addr | 32'h1;
                1: addr = addr | 32'h0800_0000;
                default: ;
            endcase
            drive_txn(we, addr, $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
        end
    endtask

    initial begin
        test_reset();
        test_read_wait();
        test_write_ack_delay();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d completions outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
